twiddle_mult_pipe: RTL and testbench
====================================

// Module: twiddle_mult_pipe
// PURPOSE
//  Pipelined, parametrised complex multiplier: out = in * W (or in * conj(W) for IFFT).
//  Sits between butterfly stages of the FFT datapath; next generation of our combinational
//  twiddle multiplier.
//  Adds a valid/ready stream handshake, configurable widths and fractional point,
//  round-half-up, saturation, a per-sample conjugate select and a sticky overflow flag.
// PARAMETERS
//  DW    16  width of each input/output component (real, imag), two's complement
//  TW    16  width of each twiddle component, two's complement
//  FRAC  8   fractional bits of twiddle (W = 1.0 is 1<<FRAC); product right-shift amount
//  RND   1   1: round-half-up (add 1<<(FRAC-1) before shift); 0: truncate (legacy behaviour)
//  SAT   1   1: saturate result to DW bits; 0: wrap (keep low DW bits)
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      input sample valid
//  in_ready   out  1      block can accept a sample this cycle
//  in_data    in   2*DW   {real[2DW-1:DW], imag[DW-1:0]}
//  in_tw      in   2*TW   twiddle {real[2TW-1:TW], imag[TW-1:0]}, sampled with in_data
//  in_conj    in   1      1: use conj(W) for this sample (inverse transform)
//  out_valid  out  1      output sample valid
//  out_ready  in   1      downstream accepts output
//  out_data   out  2*DW   {real, imag} result
//  out_sat    out  1      this output sample was saturated (either component); qualified by out_valid
//  ovf_sticky out  1      set on any saturated output handshake; cleared only by ovf_clr or reset
//  ovf_clr    in   1      clears ovf_sticky (set wins if same cycle as a saturating output)
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all stage valids, out_valid, out_sat, ovf_sticky -> 0;
//    out_data -> 0. Reset mid-stream discards all in-flight samples; in_ready=1 the cycle after.
//  - Transfer occurs when valid & ready both high at a clock edge.
//  - Latency: exactly 3 cycles from input transfer to out_valid, pipeline never stalled.
//  - Stall: global enable en = out_ready | ~out_valid; in_ready = en. When en=0 every stage
//    holds; no sample dropped or duplicated; order preserved. Bubbles are not collapsed.
//  - Stage 1: register in_data, in_tw; if in_conj, tw_imag := -tw_imag (TW+1 bits, so
//    negating the most-negative value is exact).
//  - Stage 2: four signed products ar*wr, ai*wi, ai*wr, ar*wi, each DW+TW+1 bits.
//  - Stage 3: re = ar*wr - ai*wi; im = ai*wr + ar*wi (DW+TW+2 bits, no overflow);
//    optional rounding add, arithmetic shift right FRAC; then SAT or wrap to DW bits.
//    Saturation range [-2^(DW-1), 2^(DW-1)-1]; out_sat = 1 if either component clipped.
//    With SAT=0, out_sat is always 0.
//  - Component sign convention: real in upper half, imag in lower half, every port.
//  - out_data/out_sat hold stable while out_valid=1 and out_ready=0.
//  - ovf_sticky: set when out_valid & out_ready & out_sat; ovf_clr in same cycle loses.
//  - FRAC=0 legal: no shift, rounding add disabled.
// STRUCTURE
//  - Shared package fft_pkg: DW/TW/FRAC defaults, function pack_cplx/unpack_cplx,
//    function sat_shift(value, FRAC, DW, RND, SAT) returning {sat_flag, result}.
//  - One natural sub-module: cplx_round_sat (shift/round/saturate one component),
//    instantiated twice in stage 3. Pipeline registers and handshake in the top.
// TESTING (DW=16, TW=16, FRAC=8, RND=1, SAT=1 unless stated)
//  1 in=(100,50), W=(0x0100,0x0000) -> out=(100,50) exactly 3 cycles later, out_sat=0.
//  2 in=(100,50), W=(0x0000,0xFF00) [-j] -> (50,-100); same with in_conj=1 -> (-50,100).
//  3 in=(3,0), W=(0x0080,0) [0.5]: RND=1 -> (2,0); RND=0 build -> (1,0); in=(-3,0),RND=1 -> (-1,0).
//  4 in=(0x7FFF,0x7FFF), W=(0x0100,0xFF00) -> (0x7FFF,0x0000), out_sat=1, ovf_sticky=1 next cycle;
//    ovf_clr pulse -> ovf_sticky=0; SAT=0 build -> real wraps to 0xFFFE, out_sat=0.
//  5 stream 20 random samples with in_valid=1, out_ready random (incl. 5-cycle low run)
//    -> outputs match golden model, same order, count 20, no holds violated.
//  6 assert rst_n=0 with 3 samples in flight -> next cycle out_valid=0, in_ready=1; no
//    stale sample emerges after rst_n returns high.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath helpers: default widths, complex pack/unpack and the
// shift/round/saturate primitive used by the twiddle multiplier.
package fft_pkg;

    localparam int DW_DEF   = 16;
    localparam int TW_DEF   = 16;
    localparam int FRAC_DEF = 8;

    // Components are at most 32 bits; the packed word is {re, im}, each w bits wide.
    function automatic logic [63:0] pack_cplx(input logic [31:0] re, input logic [31:0] im,
                                              input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return (({32'd0, re} & m) << w) | ({32'd0, im} & m);
    endfunction

    // Returns the sign-extended real (upper=1) or imaginary (upper=0) component.
    function automatic logic signed [31:0] unpack_cplx(input logic [63:0] data, input int w,
                                                       input bit upper);
        logic [63:0] m;
        logic [63:0] d;
        m = (64'd1 << w) - 64'd1;
        d = (upper ? (data >> w) : data) & m;
        if (((d >> (w - 1)) & 64'd1) != 64'd0)
            d = d | ~m;
        return 32'(d);
    endfunction

    // Returns {sat_flag, result}; result is sign-extended to 64 bits.
    function automatic logic [64:0] sat_shift(input logic signed [63:0] value, input int frac,
                                              input int dw, input bit rnd, input bit sat);
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic               flag;
        v = value;
        if (rnd && frac > 0)
            v = v + (64'sd1 <<< (frac - 1));
        v    = v >>> frac;
        hi   = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (dw - 1));
        flag = 1'b0;
        if (sat) begin
            if (v > hi) begin
                v    = hi;
                flag = 1'b1;
            end else if (v < lo) begin
                v    = lo;
                flag = 1'b1;
            end
        end
        return {flag, v};
    endfunction

endpackage

// File: rtl/cplx_round_sat.sv
// Shift/round/saturate of one complex component from full product width
// down to DW bits.
module cplx_round_sat
    import fft_pkg::*;
#(
    parameter int VW   = 34,
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int RND  = 1,
    parameter int SAT  = 1
) (
    input  logic signed [VW-1:0] value,
    output logic [DW-1:0]        result,
    output logic                 sat
);

    logic [64:0] r;
    logic        unused_bits;

    assign r      = sat_shift(64'(value), FRAC, DW, RND != 0, SAT != 0);
    assign result = r[DW-1:0];
    assign sat    = r[64];
    // Upper bits are either a sign extension of result or dropped on wrap.
    assign unused_bits = ^r[63:DW];

endmodule

// File: rtl/twiddle_mult_pipe.sv
// Three-stage pipelined complex multiplier out = in * W (or in * conj(W)),
// valid/ready stream with a global stall enable and a sticky overflow flag.
module twiddle_mult_pipe
    import fft_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int TW   = TW_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int RND  = 1,
    parameter int SAT  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] in_data,
    input  logic [2*TW-1:0] in_tw,
    input  logic            in_conj,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] out_data,
    output logic            out_sat,
    output logic            ovf_sticky,
    input  logic            ovf_clr
);

    localparam int PW     = DW + TW + 1;
    localparam int SW     = DW + TW + 2;
    localparam int CW     = 2 * DW;
    localparam int STAGES = 3;

    logic              en;
    logic [STAGES:1]   vld_pipe;

    logic signed [DW-1:0] in_ar, in_ai;
    logic signed [TW-1:0] in_wr, in_wi;
    logic signed [TW:0]   wi_ext;

    logic signed [DW-1:0] s1_ar, s1_ai;
    logic signed [TW-1:0] s1_wr;
    logic signed [TW:0]   s1_wi;

    logic signed [PW-1:0] s2_rr, s2_ii, s2_ir, s2_ri;

    logic signed [SW-1:0] re_sum, im_sum;
    logic [DW-1:0]        re_res, im_res;
    logic                 re_sat, im_sat;

    // A full output register that is not being drained freezes every stage.
    assign en        = out_ready | ~out_valid;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];

    assign in_ar  = DW'(unpack_cplx(64'(in_data), DW, 1'b1));
    assign in_ai  = DW'(unpack_cplx(64'(in_data), DW, 1'b0));
    assign in_wr  = TW'(unpack_cplx(64'(in_tw), TW, 1'b1));
    assign in_wi  = TW'(unpack_cplx(64'(in_tw), TW, 1'b0));
    // One extra bit so conj of the most-negative twiddle imag is exact.
    assign wi_ext = {in_wi[TW-1], in_wi};

    assign re_sum = SW'(s2_rr) - SW'(s2_ii);
    assign im_sum = SW'(s2_ir) + SW'(s2_ri);

    cplx_round_sat #(.VW(SW), .DW(DW), .FRAC(FRAC), .RND(RND), .SAT(SAT)) u_re (
        .value  (re_sum),
        .result (re_res),
        .sat    (re_sat)
    );

    cplx_round_sat #(.VW(SW), .DW(DW), .FRAC(FRAC), .RND(RND), .SAT(SAT)) u_im (
        .value  (im_sum),
        .result (im_res),
        .sat    (im_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_wr    <= '0;
            s1_wi    <= '0;
            s2_rr    <= '0;
            s2_ii    <= '0;
            s2_ir    <= '0;
            s2_ri    <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1_ar    <= in_ar;
            s1_ai    <= in_ai;
            s1_wr    <= in_wr;
            s1_wi    <= in_conj ? -wi_ext : wi_ext;
            s2_rr    <= PW'(s1_ar) * PW'(s1_wr);
            s2_ii    <= PW'(s1_ai) * PW'(s1_wi);
            s2_ir    <= PW'(s1_ai) * PW'(s1_wr);
            s2_ri    <= PW'(s1_ar) * PW'(s1_wi);
            out_data <= CW'(pack_cplx(32'(re_res), 32'(im_res), DW));
            out_sat  <= re_sat | im_sat;
        end
    end

    // Set has priority over clear so a saturation is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_sticky <= 1'b0;
        else if (out_valid && out_ready && out_sat)
            ovf_sticky <= 1'b1;
        else if (ovf_clr)
            ovf_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// Scoreboard bench for twiddle_mult_pipe: expectations come from an integer
// reference model at issue time; an output monitor pops and compares.
module tb_twiddle_mult_pipe;

    localparam int DW   = 16;
    localparam int TW   = 16;
    localparam int FRAC = 8;
    localparam int RND  = 1;
    localparam int SAT  = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2*DW-1:0] in_data = '0;
    logic [2*TW-1:0] in_tw = '0;
    logic            in_conj = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [2*DW-1:0] out_data;
    logic            out_sat;
    logic            ovf_sticky;
    logic            ovf_clr = 1'b0;

    twiddle_mult_pipe #(.DW(DW), .TW(TW), .FRAC(FRAC), .RND(RND), .SAT(SAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_tw      (in_tw),
        .in_conj    (in_conj),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint re;
        longint im;
        bit     sat;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: scale by 2^FRAC with floor division, optional half-up rounding, clip or wrap.
    function automatic longint scale(input longint v, output bit clip);
        longint d, q, lim, span;
        d = 1;
        for (int i = 0; i < FRAC; i++) d = d * 2;
        if (RND != 0 && FRAC > 0) v = v + d / 2;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        lim  = 1;
        for (int i = 0; i < DW - 1; i++) lim = lim * 2;
        span = lim * 2;
        clip = 1'b0;
        if (SAT != 0) begin
            if (q > lim - 1) begin q = lim - 1; clip = 1'b1; end
            else if (q < -lim) begin q = -lim; clip = 1'b1; end
        end else begin
            q = ((q % span) + span) % span;
            if (q >= lim) q = q - span;
        end
        return q;
    endfunction

    function automatic exp_t model(input longint ar, input longint ai, input longint wr,
                                   input longint wi, input bit conj);
        exp_t   e;
        longint w_im;
        bit     c1, c2;
        w_im  = conj ? -wi : wi;
        e.re  = scale(ar * wr - ai * w_im, c1);
        e.im  = scale(ai * wr + ar * w_im, c2);
        e.sat = c1 | c2;
        return e;
    endfunction

    // Issue side: every accepted input pushes its expected result.
    initial forever begin
        @(negedge clk);
        if (rst_n && in_valid && in_ready)
            sbq.push_back(model(longint'($signed(in_data[2*DW-1:DW])),
                                longint'($signed(in_data[DW-1:0])),
                                longint'($signed(in_tw[2*TW-1:TW])),
                                longint'($signed(in_tw[TW-1:0])), in_conj));
    end

    // Output side: compare on each handshake and check stalled outputs stay put.
    initial begin
        bit              hold_pend;
        logic [2*DW-1:0] hd;
        logic            hs;
        exp_t            e;
        hold_pend = 1'b0;
        hd = '0;
        hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, hd);
                    chk("hold_sat", out_sat, hs);
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_out", out_valid, 0);
                    end else begin
                        e = sbq.pop_front();
                        n_out++;
                        chk("out_re", longint'($signed(out_data[2*DW-1:DW])), e.re);
                        chk("out_im", longint'($signed(out_data[DW-1:0])), e.im);
                        chk("out_sat", out_sat, e.sat);
                    end
                end
                hold_pend = out_valid && !out_ready;
                hd = out_data;
                hs = out_sat;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input int ar, input int ai, input int wr, input int wi, input bit conj);
        int t;
        bit acc;
        t = 0;
        in_data  = {DW'(ar), DW'(ai)};
        in_tw    = {TW'(wr), TW'(wi)};
        in_conj  = conj;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) chk("send_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid_timeout", out_valid, 1);
    endtask

    initial begin
        int base;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_ovf_sticky", ovf_sticky, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        idle(2);

        // Identity twiddle and three-cycle latency
        send(100, 50, 256, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("latency_early", out_valid, 0);
        @(negedge clk);
        chk("latency_3", out_valid, 1);
        idle(3);

        // -j twiddle, plain and conjugated
        send(100, 50, 0, -256, 0);
        send(100, 50, 0, -256, 1);
        idle(5);

        // Rounding at exactly half, both signs
        send(3, 0, 128, 0, 0);
        send(-3, 0, 128, 0, 0);
        // Conjugating the most-negative twiddle imag
        send(1, 1, 0, -32768, 1);
        idle(6);
        chk("sticky_pre", ovf_sticky, 0);

        // Saturation sets sticky; clear pulse drops it
        send(32767, 32767, 256, -256, 0);
        wait_out();
        chk("sat_out_sat", out_sat, 1);
        @(posedge clk);
        #1;
        chk("sticky_set", ovf_sticky, 1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("sticky_clr", ovf_sticky, 0);

        // Clear held across a saturating handshake: set wins
        ovf_clr = 1'b1;
        send(-32768, 32767, 256, -256, 0);
        wait_out();
        @(posedge clk);
        #1;
        chk("sticky_set_wins", ovf_sticky, 1);
        ovf_clr = 1'b0;
        idle(3);

        // Random stream with backpressure, including a 5-cycle ready-low run
        base = n_out;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    int ar, ai, wr, wi;
                    if ($urandom_range(0, 3) == 0) begin
                        ar = int'($urandom_range(0, 65535)) - 32768;
                        ai = int'($urandom_range(0, 65535)) - 32768;
                    end else begin
                        ar = int'($urandom_range(0, 4000)) - 2000;
                        ai = int'($urandom_range(0, 4000)) - 2000;
                    end
                    wr = int'($urandom_range(0, 512)) - 256;
                    wi = int'($urandom_range(0, 512)) - 256;
                    send(ar, ai, wr, wi, 1'($urandom_range(0, 1)));
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = (c >= 4 && c < 9) ? 1'b0 : 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        begin
            int t;
            t = 0;
            while (sbq.size() != 0 && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        idle(1);
        chk("rand_drain", sbq.size(), 0);
        chk("rand_count", n_out - base, 20);

        // Reset with samples in flight: nothing stale may emerge
        send(10, 20, 256, 0, 0);
        send(30, 40, 256, 0, 0);
        send(50, 60, 256, 0, 0);
        rst_n = 1'b0;
        sbq.delete();
        base = n_out;
        idle(1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_sticky", ovf_sticky, 0);
        rst_n = 1'b1;
        idle(10);
        chk("midrst_no_stale", n_out, base);
        send(-7, 9, 0, 256, 0);
        idle(6);
        chk("post_rst_count", n_out - base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
